// File: rtl/serial_asm_pkg.sv
// Shared types and helpers for the serial word assembler.
// The fill counter must reach N inclusive, hence N+1 states.
package serial_asm_pkg;

  typedef enum logic [0:0] {
    StFill,
    StFull
  } asm_state_e;

  function automatic int unsigned fill_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_word_assembler_if.sv
// Serial-in / parallel-out handshake bundle for the serial word assembler.
// master = bit source and word sink; slave = the assembler.
interface serial_word_assembler_if #(
  parameter int unsigned N = 9
);

  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic         flush;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         word_ready;

  modport master (
    output bit_in, bit_valid, flush, word_ready,
    input  bit_ready, word_out, word_valid
  );

  modport slave (
    input  bit_in, bit_valid, flush, word_ready,
    output bit_ready, word_out, word_valid
  );

endinterface

// File: rtl/word_out_slot.sv
// One-entry valid/ready output register slice.
// A load in the same cycle as a drain keeps the slot full with the new word.
module word_out_slot #(
  parameter int unsigned N = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         empty_or_draining_o
);

  logic         valid_q;
  logic [N-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o             = valid_q;
  assign data_o              = data_q;
  assign empty_or_draining_o = !valid_q || ready_i;

endmodule

// File: rtl/serial_word_assembler.sv
// Bit-serial to N-bit parallel word assembler feeding the popcount stage.
// Shift register plus one output slot allows one word every N bits with no bubbles.
module serial_word_assembler
  import serial_asm_pkg::*;
#(
  parameter int unsigned N         = 9,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned WCW       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_word_assembler_if.slave     bus,
  output logic [fill_width(N)-1:0]   fill_level,
  output logic                       frag_drop,
  output logic [WCW-1:0]             word_cnt
);

  localparam int unsigned CW = fill_width(N);
  localparam logic [CW-1:0] FillLast = CW'(N - 1);
  localparam logic [CW-1:0] FillFull = CW'(N);

  asm_state_e     state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [CW-1:0]  fill_q, fill_d;
  logic           frag_q, frag_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           run_q;

  logic           bit_acc;
  logic [N-1:0]   shifted;
  logic           load;
  logic [N-1:0]   load_data;
  logic           slot_eod;

  word_out_slot #(
    .N (N)
  ) u_slot (
    .clk                 (clk),
    .rst_n               (rst_n),
    .load_i              (load),
    .data_i              (load_data),
    .ready_i             (bus.word_ready),
    .valid_o             (bus.word_valid),
    .data_o              (bus.word_out),
    .empty_or_draining_o (slot_eod)
  );

  // run_q keeps bit_ready low until the first cycle after reset release.
  assign bus.bit_ready = run_q && (state_q == StFill);
  assign bit_acc       = bus.bit_valid && bus.bit_ready;

  always_comb begin
    if (LSB_FIRST) begin
      shifted = {bus.bit_in, sr_q[N-1:1]};
    end else begin
      shifted = {sr_q[N-2:0], bus.bit_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    frag_d    = 1'b0;
    load      = 1'b0;
    load_data = sr_q;
    unique case (state_q)
      StFill: begin
        if (bus.flush) begin
          fill_d = '0;
          frag_d = (fill_q != '0) || bit_acc;
        end else if (bit_acc) begin
          if (fill_q == FillLast) begin
            if (slot_eod) begin
              load      = 1'b1;
              load_data = shifted;
              fill_d    = '0;
            end else begin
              sr_d    = shifted;
              fill_d  = FillFull;
              state_d = StFull;
            end
          end else begin
            sr_d   = shifted;
            fill_d = fill_q + CW'(1);
          end
        end
      end
      StFull: begin
        if (slot_eod) begin
          load    = 1'b1;
          fill_d  = '0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign cnt_d = (bus.word_valid && bus.word_ready) ? cnt_q + WCW'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
      sr_q    <= '0;
      fill_q  <= '0;
      frag_q  <= 1'b0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      frag_q  <= frag_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign fill_level = fill_q;
  assign frag_drop  = frag_q;
  assign word_cnt   = cnt_q;

endmodule
